// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem read port and a
// small in-order instruction queue feeding decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // state  | meaning
  // S_IDLE | no request outstanding; issue when the queue has credit
  // S_WAIT | request accepted, response will be pushed into the queue
  // S_DROP | request accepted, then cancelled by a redirect; response is discarded
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q;
  logic [31:0]   last_pc_q;
  logic          started_q;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          outstanding;
  logic [PW+1:0] inflight;
  logic          credit_ok;
  logic          fire;
  logic          push;
  logic          pop;
  logic          unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc_i[1:0];

  assign outstanding = (state_q != S_IDLE);
  assign inflight    = {1'b0, count_q} + {{(PW+1){1'b0}}, outstanding};
  assign credit_ok   = (inflight < DEPTH_W);

  // started_q keeps imem_req low while rst_n is asserted
  assign imem_req_o  = started_q && (state_q == S_IDLE) && credit_ok && !redirect_valid_i;
  assign imem_addr_o = fetch_pc_q;
  assign fire        = imem_req_o && imem_ready_i;

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem[head_q] : NOP;
  assign inst_pc_o    = inst_valid_o ? pc_mem[head_q] : last_pc_q;

  assign push = (state_q == S_WAIT) && imem_rvalid_i && !redirect_valid_i;
  assign pop  = inst_valid_o && inst_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (fire) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i)         state_d = S_IDLE;
        else if (redirect_valid_i) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid_i)  fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (fire)         fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      started_q  <= 1'b0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      started_q  <= 1'b1;
      if (fire)         req_pc_q  <= fetch_pc_q;
      if (inst_valid_o) last_pc_q <= pc_mem[head_q];
    end
  end

  // a redirect wins over push/pop: the queue simply restarts empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect_valid_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_rdata_i;
      pc_mem[tail_q]   <= req_pc_q;
    end
  end

endmodule
